// File: rtl/handshake_fifo.sv
// handshake_fifo: elastic FIFO stage whose in_ready is derived only from registered state.
// Optional zero-latency pass-through when empty is enabled by defining LOOM_FIFO_BYPASS_EN.
module handshake_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("handshake_fifo: DEPTH must be >= 1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en_c, rd_en_c;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshake outputs and next-state; ready never looks at out_ready.
  always_comb begin
    in_ready  = !rst && (count_q != CW'(DEPTH));
    out_valid = !rst && (count_q != '0);
    out_data  = mem_q[rd_ptr_q];
    wr_en_c   = in_valid && in_ready;
    rd_en_c   = out_valid && out_ready;
`ifdef LOOM_FIFO_BYPASS_EN
    // Empty with a word arriving: present it directly, store it only if not taken.
    if (!rst && (count_q == '0) && in_valid) begin
      out_valid = 1'b1;
      out_data  = in_data;
      wr_en_c   = !out_ready;
      rd_en_c   = 1'b0;
    end
`endif
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_c) wr_ptr_d = next_ptr(wr_ptr_q);
    if (rd_en_c) rd_ptr_d = next_ptr(rd_ptr_q);
    case ({wr_en_c, rd_en_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset; occupancy tracking makes stale words invisible.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= in_data;
  end

  assign count = count_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: vector table plus queue scoreboard for DEPTH=2 and DEPTH=3 instances.
module tb_handshake_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        rst2, iv2, ir2, ov2, or2;
  logic [15:0] id2, od2;
  logic [1:0]  cnt2;
  // DEPTH=3 instance
  logic        rst3, iv3, ir3, ov3, or3;
  logic [15:0] id3, od3;
  logic [1:0]  cnt3;

  handshake_fifo #(.WIDTH(16), .DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
  );

  handshake_fifo #(.WIDTH(16), .DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference queues: words enter on an accepted push and leave on an accepted pop.
  logic [15:0] q2[$];
  logic [15:0] q3[$];

  always @(posedge clk) begin
    bit pop2, push2, pop3, push3;
    if (rst2) q2.delete();
    else begin
      pop2  = (q2.size() != 0) && or2;
      push2 = iv2 && (q2.size() != 2);
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back(id2);
    end
    if (rst3) q3.delete();
    else begin
      pop3  = (q3.size() != 0) && or3;
      push3 = iv3 && (q3.size() != 3);
      if (pop3) void'(q3.pop_front());
      if (push3) q3.push_back(id3);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sb2_in_ready", 32'(ir2), 32'(!rst2 && q2.size() != 2));
      chk("sb2_out_valid", 32'(ov2), 32'(!rst2 && q2.size() != 0));
      chk("sb2_count", 32'(cnt2), 32'(q2.size()));
      if (!rst2 && q2.size() != 0) chk("sb2_out_data", 32'(od2), 32'(q2[0]));
      chk("sb3_in_ready", 32'(ir3), 32'(!rst3 && q3.size() != 3));
      chk("sb3_out_valid", 32'(ov3), 32'(!rst3 && q3.size() != 0));
      chk("sb3_count", 32'(cnt3), 32'(q3.size()));
      chk("sb3_count_le3", 32'(cnt3 <= 2'd3), 32'(1));
      if (!rst3 && q3.size() != 0) chk("sb3_out_data", 32'(od3), 32'(q3[0]));
    end
  end

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [1:0]  e_cnt;
    logic [15:0] e_dat;
  } vec_t;

  function automatic vec_t mk(input int r, input int v, input int d, input int o,
                              input int eir, input int eov, input int ec, input int ed);
    vec_t t;
    t.rst = 1'(r); t.iv = 1'(v); t.d = 16'(d); t.ordy = 1'(o);
    t.e_ir = 1'(eir); t.e_ov = 1'(eov); t.e_cnt = 2'(ec); t.e_dat = 16'(ed);
    return t;
  endfunction

  vec_t tbl[22];

  initial begin
    int sent, rcvd, cyc;

    // rst, in_valid, in_data, out_ready -> in_ready, out_valid, count, out_data
    tbl[0]  = mk(1, 1, 'hDEAD, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 'hDEAD, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,      0, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 'h11,   0, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 'h22,   0, 1, 1, 1, 'h11);
    tbl[5]  = mk(0, 0, 0,      0, 0, 1, 2, 'h11);
    tbl[6]  = mk(0, 0, 0,      1, 0, 1, 2, 'h11);
    tbl[7]  = mk(0, 0, 0,      1, 1, 1, 1, 'h22);
    tbl[8]  = mk(0, 0, 0,      0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 'hAA,   0, 1, 0, 0, 0);
    tbl[10] = mk(0, 1, 'hBB,   0, 1, 1, 1, 'hAA);
    tbl[11] = mk(0, 1, 'h33,   1, 0, 1, 2, 'hAA);
    tbl[12] = mk(0, 1, 'h33,   0, 1, 1, 1, 'hBB);
    tbl[13] = mk(0, 0, 0,      1, 0, 1, 2, 'hBB);
    tbl[14] = mk(0, 0, 0,      1, 1, 1, 1, 'h33);
    tbl[15] = mk(0, 0, 0,      0, 1, 0, 0, 0);
    tbl[16] = mk(0, 1, 'h44,   0, 1, 0, 0, 0);
    tbl[17] = mk(0, 1, 'h55,   0, 1, 1, 1, 'h44);
    tbl[18] = mk(1, 0, 0,      0, 0, 0, 2, 0);
    tbl[19] = mk(0, 1, 'h66,   0, 1, 0, 0, 0);
    tbl[20] = mk(0, 0, 0,      1, 1, 1, 1, 'h66);
    tbl[21] = mk(0, 0, 0,      0, 1, 0, 0, 0);

    rst2 = 1'b1; iv2 = 1'b0; id2 = '0; or2 = 1'b0;
    rst3 = 1'b1; iv3 = 1'b0; id3 = '0; or3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk_en = 1'b1;

    // Reset hold, fill/drain, full-with-pop, and mid-operation reset
    for (int i = 0; i < 22; i++) begin
      rst2 = tbl[i].rst; iv2 = tbl[i].iv; id2 = tbl[i].d; or2 = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(ir2), 32'(tbl[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(ov2), 32'(tbl[i].e_ov));
      chk($sformatf("vec%0d_count", i), 32'(cnt2), 32'(tbl[i].e_cnt));
      if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), 32'(od2), 32'(tbl[i].e_dat));
      @(posedge clk); #1;
    end

    // Streaming: one push and one pop per cycle once primed
    for (int i = 0; i <= 10; i++) begin
      rst2 = 1'b0; iv2 = (i < 10); id2 = 16'(i); or2 = 1'b1;
      @(negedge clk);
      chk($sformatf("stream%0d_count", i), 32'(cnt2), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("stream%0d_out_valid", i), 32'(ov2), (i == 0) ? 32'd0 : 32'd1);
      if (i != 0) chk($sformatf("stream%0d_out_data", i), 32'(od2), 32'(i - 1));
      @(posedge clk); #1;
    end
    iv2 = 1'b0; or2 = 1'b0;

    // Wrap-around on DEPTH=3 with random stalls on both sides
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < 7 && cyc < 300) begin
      iv3 = (sent < 7) && ($urandom_range(0, 2) != 0);
      id3 = 16'(16'hA0 + sent);
      or3 = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (iv3 && ir3) sent++;
      if (ov3 && or3) begin
        chk($sformatf("wrap_order%0d", rcvd), 32'(od3), 32'(16'hA0 + rcvd));
        rcvd++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("wrap_all_received", 32'(rcvd), 32'd7);
    iv3 = 1'b0; or3 = 1'b0;
    @(negedge clk);
    chk("wrap_empty_after", 32'(cnt3), 32'd0);
    @(posedge clk); #1;

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
